dmem_copy_engine: RTL and testbench

//  Bus master (initiator) for the 16-bit data memory port: drives address/writedata/memread/memwrite.

---
 rtl/cpu16_pkg.sv | 23 ++
 rtl/dmem_copy_engine.sv | 132 +++++++++++++
 tb/tb_dmem_copy_engine.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared constants and types for the 16-bit CPU data-memory side blocks.
// Used by dmem_copy_engine.
package cpu16_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 11;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1024);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } copy_state_t;

    // A full memory's worth of words is the largest copy that makes sense.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/dmem_copy_engine.sv
// Block copy master for the 16-bit data memory port: one read/write pair per word.
// Optional running checksum of the words read, enabled by DMEM_COPY_CHECKSUM_EN.
module dmem_copy_engine
    import cpu16_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_src_addr,
    input  logic [ADDR_W-1:0] i_dst_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_writedata,
    output logic              o_mem_memread,
    output logic              o_mem_memwrite,
    input  logic [DATA_W-1:0] i_mem_readdata
`ifdef DMEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] o_checksum
`endif
);

    copy_state_t       r_state;
    copy_state_t       w_next_state;
    logic [ADDR_W-1:0] r_src_q;
    logic [ADDR_W-1:0] r_dst_q;
    logic [LEN_W-1:0]  r_rem_q;
    logic [DATA_W-1:0] r_data_q;
    logic [LEN_W-1:0]  w_len_clamped;
    logic              w_accept;

    assign w_len_clamped = clamp_len(i_length);
    assign w_accept      = (r_state == IDLE) && i_start;

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = (w_len_clamped != '0) ? RD : DONE;
                end
            end
            RD:      w_next_state = WR;
            WR:      w_next_state = (r_rem_q != LEN_W'(1)) ? RD : DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_src_q  <= '0;
            r_dst_q  <= '0;
            r_rem_q  <= '0;
            r_data_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_src_q <= i_src_addr;
                        r_dst_q <= i_dst_addr;
                        r_rem_q <= w_len_clamped;
                    end
                end
                RD: begin
                    r_data_q <= i_mem_readdata;
                    r_src_q  <= r_src_q + ADDR_W'(1);
                end
                WR: begin
                    r_dst_q <= r_dst_q + ADDR_W'(1);
                    r_rem_q <= r_rem_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Moore outputs: the bus is parked at zero whenever no transfer is in flight.
    always_comb begin
        o_busy          = 1'b0;
        o_done          = 1'b0;
        o_mem_address   = '0;
        o_mem_writedata = '0;
        o_mem_memread   = 1'b0;
        o_mem_memwrite  = 1'b0;
        case (r_state)
            RD: begin
                o_busy        = 1'b1;
                o_mem_memread = 1'b1;
                o_mem_address = r_src_q;
            end
            WR: begin
                o_busy          = 1'b1;
                o_mem_memwrite  = 1'b1;
                o_mem_address   = r_dst_q;
                o_mem_writedata = r_data_q;
            end
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

`ifdef DMEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_reset || w_accept) begin
            r_checksum <= '0;
        end else if (r_state == RD) begin
            r_checksum <= r_checksum + i_mem_readdata;
        end
    end

    assign o_checksum = r_checksum;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Randomized bench for dmem_copy_engine: a bus-operation scoreboard derived from the copy
// rules is compared every cycle, with a bench-owned data memory as the responder.
module tb_dmem_copy_engine;

    localparam logic [1:0] K_RD   = 2'd0;
    localparam logic [1:0] K_WR   = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [9:0]  addr;
        logic [15:0] data;
    } op_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  src;
    logic [9:0]  dst;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [9:0]  maddr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic [15:0] rdata;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    always #5 clk = ~clk;

    dmem_copy_engine dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_src_addr      (src),
        .i_dst_addr      (dst),
        .i_length        (len),
        .o_busy          (busy),
        .o_done          (done),
        .o_mem_address   (maddr),
        .o_mem_writedata (wdata),
        .o_mem_memread   (rd),
        .o_mem_memwrite  (wr),
        .i_mem_readdata  (rdata)
`ifdef DMEM_COPY_CHECKSUM_EN
        ,
        .o_checksum      (checksum)
`endif
    );

    // Data memory acting as responder: combinational read, write on the clock edge.
    logic [15:0] tb_mem  [1024];
    logic [15:0] ref_mem [1024];
    logic [15:0] shadow  [1024];

    assign rdata = rd ? tb_mem[maddr] : 16'h0000;

    always @(posedge clk) begin
        if (wr) tb_mem[maddr] = wdata;
    end

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;
    op_t q[$];
    logic [15:0] exp_ck = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] pack_bus(input logic b, input logic d, input logic r,
                                             input logic w, input logic [9:0] a,
                                             input logic [15:0] wd);
        return {b, d, r, w, a, wd};
    endfunction

    function automatic int eff_len(input logic [10:0] l);
        return (l > 11'd1024) ? 1024 : int'(l);
    endfunction

    // Expand an accepted request into the exact bus operations it must produce.
    task automatic accept(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l);
        int n;
        op_t op;
        logic [9:0] sa;
        logic [9:0] da;
        n = eff_len(l);
        for (int i = 0; i < 1024; i++) shadow[i] = ref_mem[i];
        for (int i = 0; i < n; i++) begin
            sa = 10'((int'(s) + i) % 1024);
            da = 10'((int'(d) + i) % 1024);
            op = '{kind: K_RD, addr: sa, data: shadow[sa]};
            q.push_back(op);
            op = '{kind: K_WR, addr: da, data: shadow[sa]};
            q.push_back(op);
            shadow[da] = shadow[sa];
        end
        op = '{kind: K_DONE, addr: 10'h0, data: 16'h0};
        q.push_back(op);
        exp_ck = 16'h0;
    endtask

    // Model advance: one scheduled operation retires per clock edge.
    always @(posedge clk) begin
        op_t op;
        if (reset) begin
            q.delete();
            exp_ck = 16'h0;
        end else if (q.size() != 0) begin
            op = q.pop_front();
            if (op.kind == K_WR) ref_mem[op.addr] = op.data;
            else if (op.kind == K_RD) exp_ck = exp_ck + op.data;
        end else if (start) begin
            accept(src, dst, len);
        end
    end

    // Compare: the DUT bus must show the operation at the head of the schedule.
    always @(negedge clk) begin
        logic [29:0] exp_bus;
        string nm;
        if (cmp_en) begin
            exp_bus = '0;
            nm = "bus_idle";
            if (q.size() != 0) begin
                case (q[0].kind)
                    K_RD: begin
                        exp_bus = pack_bus(1'b1, 1'b0, 1'b1, 1'b0, q[0].addr, 16'h0);
                        nm = "bus_read";
                    end
                    K_WR: begin
                        exp_bus = pack_bus(1'b1, 1'b0, 1'b0, 1'b1, q[0].addr, q[0].data);
                        nm = "bus_write";
                    end
                    default: begin
                        exp_bus = pack_bus(1'b0, 1'b1, 1'b0, 1'b0, 10'h0, 16'h0);
                        nm = "bus_done";
                    end
                endcase
            end
            check(nm, 32'(pack_bus(busy, done, rd, wr, maddr, wdata)), 32'(exp_bus));
`ifdef DMEM_COPY_CHECKSUM_EN
            check("checksum_track", 32'(checksum), 32'(exp_ck));
`endif
        end
    end

    task automatic poke(input logic [9:0] a, input logic [15:0] v);
        tb_mem[a]  = v;
        ref_mem[a] = v;
    endtask

    task automatic start_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l);
        @(posedge clk);
        #1;
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
    endtask

    // Runs one copy; optionally pulses a stray start somewhere before DONE ends.
    task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] l,
                            input bit stray);
        int n;
        int k;
        int e;
        e = eff_len(l);
        k = $urandom_range(0, 2 * e);
        start_copy(s, d, l);
        fork
            wait_done(2 * e + 20, n);
            begin
                if (stray) begin
                    if (k > 0) begin
                        repeat (k) @(posedge clk);
                        #1;
                    end
                    start = 1'b1;
                    src   = 10'($urandom);
                    dst   = 10'($urandom);
                    len   = 11'($urandom_range(0, 8));
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        join
        check("latency", 32'(n), 32'(1 + 2 * e));
    endtask

    initial begin
        int n;
        int bad;
        reset = 1'b1;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        for (int i = 0; i < 1024; i++) poke(10'(i), 16'($urandom));
        @(posedge clk);
        cmp_en = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_state", 32'(pack_bus(busy, done, rd, wr, maddr, wdata)), 32'h0);

        // Basic four-word copy, done nine cycles after acceptance.
        poke(10'h010, 16'h00A1);
        poke(10'h011, 16'h00B2);
        poke(10'h012, 16'h00C3);
        poke(10'h013, 16'h00D4);
        start_copy(10'h010, 10'h200, 11'd4);
        wait_done(40, n);
        check("t1_latency", 32'(n), 32'd9);
        check("t1_dst0", 32'(tb_mem[10'h200]), 32'h00A1);
        check("t1_dst3", 32'(tb_mem[10'h203]), 32'h00D4);

        // Zero length: straight to DONE.
        start_copy(10'h055, 10'h066, 11'd0);
        wait_done(10, n);
        check("t2_latency", 32'(n), 32'd1);

        // Source wraps past the top of memory.
        poke(10'h3FE, 16'h1111);
        poke(10'h3FF, 16'h2222);
        poke(10'h000, 16'h3333);
        poke(10'h001, 16'h4444);
        start_copy(10'h3FE, 10'h100, 11'd4);
        wait_done(40, n);
        check("t3_dst1", 32'(tb_mem[10'h101]), 32'h2222);
        check("t3_dst2", 32'(tb_mem[10'h102]), 32'h3333);
        check("t3_dst3", 32'(tb_mem[10'h103]), 32'h4444);

        // Stray start during a copy is ignored.
        run_copy(10'h040, 10'h140, 11'd6, 1'b1);

        // Reset lands on the edge that would begin the third write of an 8-word copy.
        for (int i = 0; i < 8; i++) begin
            poke(10'(32 + i), 16'(16'hC000 + i));
            poke(10'(10'h220 + i), 16'h5555);
        end
        start_copy(10'h020, 10'h220, 11'd8);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_idle_after_reset", 32'(pack_bus(busy, done, rd, wr, maddr, wdata)), 32'h0);
        check("t5_dst1", 32'(tb_mem[10'h221]), 32'hC001);
        check("t5_dst2", 32'(tb_mem[10'h222]), 32'h5555);

`ifdef DMEM_COPY_CHECKSUM_EN
        poke(10'h300, 16'hFFFF);
        poke(10'h301, 16'h0002);
        start_copy(10'h300, 10'h310, 11'd2);
        wait_done(20, n);
        @(posedge clk);
        #1;
        check("t6_checksum", 32'(checksum), 32'h0001);
        start_copy(10'h000, 10'h000, 11'd0);
        check("t6_cleared", 32'(checksum), 32'h0000);
        wait_done(10, n);
`endif

        // Oversized length is clamped to a full-memory copy.
        run_copy(10'(($urandom)), 10'($urandom), 11'd1500, 1'b0);

        for (int it = 0; it < 30; it++) begin
            run_copy(10'($urandom), 10'($urandom), 11'($urandom_range(0, 20)),
                     1'($urandom_range(0, 1)));
        end

        repeat (2) @(posedge clk);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (tb_mem[i] !== ref_mem[i]) bad++;
        end
        check("mem_image", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
